// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the high-score keeper slice.
//   - default widths and RAM depth
//   - sequencer state encoding (IDLE .. DONE)
//   - request-type codes and the fixed-priority arbitration helper
// No ports; imported by hs_req_slot and high_score_keeper.
// ---------------------------------------------------------------------------
package hs_pkg;

    localparam int SCORE_W_DEF = 4;
    localparam int ADDR_W_DEF  = 4;
    localparam int DEPTH_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_CAP,
        CM_ADDR,
        CM_WAIT,
        CM_CMP,
        CLR,
        DONE
    } hsState_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CLR,
        REQ_CM,
        REQ_LD
    } hsReq_t;

    // Fixed priority: a clear-all wipes the table, so it must go before any
    // commit or load that would otherwise see stale data; a commit goes
    // before a load so a user logging in right after a game sees the update.
    function automatic hsReq_t arbitrate(input logic clrPend,
                                         input logic cmPend,
                                         input logic ldPend);
        hsReq_t req;
        req = REQ_NONE;
        if (clrPend) begin
            req = REQ_CLR;
        end else if (cmPend) begin
            req = REQ_CM;
        end else if (ldPend) begin
            req = REQ_LD;
        end
        return req;
    endfunction

endpackage

// File: rtl/hs_req_slot.sv
// ---------------------------------------------------------------------------
// hs_req_slot
// One pending-request slot: a pending bit plus the operands captured with the
// request pulse. A new pulse always sets the slot and overwrites the operands
// (last request wins), and a set on the same edge as a grant keeps the slot
// pending so the new pulse is served as a separate operation.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   set      in   request pulse
//   grant    in   arbiter has taken this request this cycle
//   din      in   operands presented with the request pulse
//   pending  out  request waiting to be served
//   dout     out  operands of the most recent request
// ---------------------------------------------------------------------------
module hs_req_slot
    import hs_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  logic         grant,
    input  logic [W-1:0] din,
    output logic         pending,
    output logic [W-1:0] dout
);

    // Set has priority over the grant-clear so a pulse landing on the grant
    // edge is never dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            dout    <= '0;
        end else begin
            if (set) begin
                pending <= 1'b1;
                dout    <= din;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/high_score_keeper.sv
// ---------------------------------------------------------------------------
// high_score_keeper
// Sequencer and arbiter in front of the per-user high-score RAM (single port,
// synchronous, 1-cycle read latency). Serves load (fetch a user's max score),
// commit (read-compare-write a finished game's score) and clear-all (zero
// every entry), each arriving as a one-cycle pulse into its own pending slot.
//
// Optional build macro:
//   NEW_RECORD_EN  adds output newRecord_s, pulsing with done_s when a commit
//                  actually stored a strictly higher score.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   loadReq_s      in   pulse: fetch the max score of userIdx
//   commitReq_s    in   pulse: offer curScore for userIdx
//   clearAllReq_s  in   pulse: zero all DEPTH entries
//   userIdx        in   user index, captured with load/commit pulses
//   curScore       in   finished-game score, captured with commit pulses
//   hisMaxScore    out  max score of the last-served user (registered)
//   busy           out  sequencer is not idle
//   done_s         out  one-cycle pulse when an operation completes
//   ram_addr       out  RAM address (registered)
//   ram_we         out  RAM write enable (registered)
//   ram_wdata      out  RAM write data (registered)
//   ram_rdata      in   RAM read data, valid the cycle after ram_addr is sampled
//   newRecord_s    out  (NEW_RECORD_EN only) commit stored a new record
// ---------------------------------------------------------------------------
module high_score_keeper
    import hs_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loadReq_s,
    input  logic               commitReq_s,
    input  logic               clearAllReq_s,
    input  logic [ADDR_W-1:0]  userIdx,
    input  logic [SCORE_W-1:0] curScore,
    output logic [SCORE_W-1:0] hisMaxScore,
    output logic               busy,
    output logic               done_s,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [SCORE_W-1:0] ram_wdata,
    input  logic [SCORE_W-1:0] ram_rdata
`ifdef NEW_RECORD_EN
    ,
    output logic               newRecord_s
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    hsState_t           state;
    hsState_t           stateNext;
    hsReq_t             req;

    logic               ldPend;
    logic               cmPend;
    logic               clrPend;
    logic [ADDR_W-1:0]  ldIdx;
    logic [ADDR_W+SCORE_W-1:0] cmData;
    logic [ADDR_W-1:0]  cmIdx;
    logic [SCORE_W-1:0] cmScore;
    logic               unusedClrOp;

    logic               grantLd;
    logic               grantCm;
    logic               grantClr;

    logic [SCORE_W-1:0] opScore;
    logic [SCORE_W-1:0] opScoreNext;
    logic               opIsClr;
    logic               opIsClrNext;

    logic [ADDR_W-1:0]  ramAddrNext;
    logic               ramWeNext;
    logic [SCORE_W-1:0] ramWdataNext;
    logic [SCORE_W-1:0] hisNext;
    logic               doneNext;
`ifdef NEW_RECORD_EN
    logic               newRecordNext;
`endif

    // One pending slot per requester. The clear slot carries no operand, so
    // its data path is a dummy bit that nothing reads.
    hs_req_slot #(.W(ADDR_W)) ldSlot (
        .clk     (clk),
        .rst     (rst),
        .set     (loadReq_s),
        .grant   (grantLd),
        .din     (userIdx),
        .pending (ldPend),
        .dout    (ldIdx)
    );

    hs_req_slot #(.W(ADDR_W + SCORE_W)) cmSlot (
        .clk     (clk),
        .rst     (rst),
        .set     (commitReq_s),
        .grant   (grantCm),
        .din     ({userIdx, curScore}),
        .pending (cmPend),
        .dout    (cmData)
    );

    hs_req_slot #(.W(1)) clrSlot (
        .clk     (clk),
        .rst     (rst),
        .set     (clearAllReq_s),
        .grant   (grantClr),
        .din     (1'b0),
        .pending (clrPend),
        .dout    (unusedClrOp)
    );

    assign cmIdx   = cmData[SCORE_W +: ADDR_W];
    assign cmScore = cmData[SCORE_W-1:0];
    assign req     = arbitrate(clrPend, cmPend, ldPend);
    assign busy    = (state != IDLE);

    // Next-state and next-output logic. The commit score is copied into
    // opScore at grant time so a repeat commit pulse arriving mid-operation
    // only updates the pending slot, not the compare already in flight.
    // During a clear sweep ram_addr doubles as the sweep counter.
    always_comb begin
        stateNext    = state;
        ramAddrNext  = ram_addr;
        ramWeNext    = ram_we;
        ramWdataNext = ram_wdata;
        hisNext      = hisMaxScore;
        doneNext     = 1'b0;
        opScoreNext  = opScore;
        opIsClrNext  = opIsClr;
        grantLd      = 1'b0;
        grantCm      = 1'b0;
        grantClr     = 1'b0;

        case (state)
            IDLE: begin
                case (req)
                    REQ_CLR: begin
                        grantClr     = 1'b1;
                        opIsClrNext  = 1'b1;
                        ramAddrNext  = '0;
                        ramWeNext    = 1'b1;
                        ramWdataNext = '0;
                        stateNext    = CLR;
                    end
                    REQ_CM: begin
                        grantCm      = 1'b1;
                        opIsClrNext  = 1'b0;
                        opScoreNext  = cmScore;
                        ramAddrNext  = cmIdx;
                        ramWeNext    = 1'b0;
                        stateNext    = CM_ADDR;
                    end
                    REQ_LD: begin
                        grantLd      = 1'b1;
                        opIsClrNext  = 1'b0;
                        ramAddrNext  = ldIdx;
                        ramWeNext    = 1'b0;
                        stateNext    = LD_ADDR;
                    end
                    default: begin
                        stateNext    = IDLE;
                    end
                endcase
            end
            LD_ADDR: begin
                stateNext = LD_CAP;
            end
            LD_CAP: begin
                hisNext   = ram_rdata;
                doneNext  = 1'b1;
                stateNext = IDLE;
            end
            CM_ADDR: begin
                stateNext = CM_WAIT;
            end
            CM_WAIT: begin
                stateNext = CM_CMP;
            end
            CM_CMP: begin
                if (opScore > ram_rdata) begin
                    ramWeNext    = 1'b1;
                    ramWdataNext = opScore;
                    hisNext      = opScore;
                end else begin
                    hisNext      = ram_rdata;
                end
                stateNext = DONE;
            end
            CLR: begin
                if (ram_addr == LAST_ADDR) begin
                    ramWeNext = 1'b0;
                    stateNext = DONE;
                end else begin
                    ramAddrNext = ram_addr + 1'b1;
                end
            end
            DONE: begin
                if (opIsClr) begin
                    hisNext = '0;
                end
                ramWeNext = 1'b0;
                doneNext  = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                ramWeNext = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

`ifdef NEW_RECORD_EN
    // A commit only reaches DONE with ram_we high when it issued a write, so
    // that is exactly the new-record condition.
    always_comb begin
        newRecordNext = (state == DONE) && ram_we && !opIsClr;
    end
`endif

    // State and registered outputs. Reset aborts any operation at once; a
    // partial sweep or an unissued write is simply lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            hisMaxScore <= '0;
            done_s      <= 1'b0;
            opScore     <= '0;
            opIsClr     <= 1'b0;
`ifdef NEW_RECORD_EN
            newRecord_s <= 1'b0;
`endif
        end else begin
            state       <= stateNext;
            ram_addr    <= ramAddrNext;
            ram_we      <= ramWeNext;
            ram_wdata   <= ramWdataNext;
            hisMaxScore <= hisNext;
            done_s      <= doneNext;
            opScore     <= opScoreNext;
            opIsClr     <= opIsClrNext;
`ifdef NEW_RECORD_EN
            newRecord_s <= newRecordNext;
`endif
        end
    end

endmodule

// File: tb/tb_high_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_high_score_keeper
// Directed self-checking bench for high_score_keeper with a behavioural
// single-port RAM (1-cycle read latency) and a write log.
// Build with NEW_RECORD_EN defined to also exercise newRecord_s.
// ---------------------------------------------------------------------------
module tb_high_score_keeper;

    localparam int SCORE_W = 4;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               loadReq_s;
    logic               commitReq_s;
    logic               clearAllReq_s;
    logic [ADDR_W-1:0]  userIdx;
    logic [SCORE_W-1:0] curScore;
    logic [SCORE_W-1:0] hisMaxScore;
    logic               busy;
    logic               done_s;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [SCORE_W-1:0] ram_wdata;
    logic [SCORE_W-1:0] ram_rdata;
`ifdef NEW_RECORD_EN
    logic               newRecord_s;
`endif

    int checks   = 0;
    int failures = 0;

    logic [SCORE_W-1:0] mem [DEPTH];
    logic               bdWe;
    logic [ADDR_W-1:0]  bdAddr;
    logic [SCORE_W-1:0] bdData;
    int                 wCount = 0;
    logic [ADDR_W-1:0]  wAddrLog [64];
    logic [SCORE_W-1:0] wDataLog [64];

    always #5 clk = ~clk;

    high_score_keeper #(
        .SCORE_W (SCORE_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .loadReq_s     (loadReq_s),
        .commitReq_s   (commitReq_s),
        .clearAllReq_s (clearAllReq_s),
        .userIdx       (userIdx),
        .curScore      (curScore),
        .hisMaxScore   (hisMaxScore),
        .busy          (busy),
        .done_s        (done_s),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
`ifdef NEW_RECORD_EN
        ,
        .newRecord_s   (newRecord_s)
`endif
    );

    // Behavioural RAM: read-first, 1-cycle read latency, with a backdoor
    // preload port and a log of every DUT write.
    always @(posedge clk) begin
        if (bdWe) begin
            mem[bdAddr] <= bdData;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            if (wCount < 64) begin
                wAddrLog[wCount] <= ram_addr;
                wDataLog[wCount] <= ram_wdata;
            end
            wCount <= wCount + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic cm, input logic clr,
                                 input logic [ADDR_W-1:0] idx,
                                 input logic [SCORE_W-1:0] score);
        @(negedge clk);
        loadReq_s     = ld;
        commitReq_s   = cm;
        clearAllReq_s = clr;
        userIdx       = idx;
        curScore      = score;
        @(negedge clk);
        loadReq_s     = 1'b0;
        commitReq_s   = 1'b0;
        clearAllReq_s = 1'b0;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [SCORE_W-1:0] d);
        @(negedge clk);
        bdWe   = 1'b1;
        bdAddr = a;
        bdData = d;
        @(negedge clk);
        bdWe   = 1'b0;
    endtask

    // Load of idx followed by the done check three cycles after the pulse.
    task automatic doLoad(input string tag, input logic [ADDR_W-1:0] idx,
                          input logic [SCORE_W-1:0] expScore);
        applyStimulus(1'b1, 1'b0, 1'b0, idx, '0);
        waitNeg(3);
        checkOutput({tag, "_done"}, done_s, 1'b1);
        checkOutput({tag, "_his"}, hisMaxScore, expScore);
    endtask

    initial begin
        int base;
        int doneCnt;
        logic prevDone;
        logic dblDone;
        logic [SCORE_W-1:0] doneHis [3];
        logic found;

        rst           = 1'b1;
        loadReq_s     = 1'b0;
        commitReq_s   = 1'b0;
        clearAllReq_s = 1'b0;
        userIdx       = '0;
        curScore      = '0;
        bdWe          = 1'b0;
        bdAddr        = '0;
        bdData        = '0;
        #2 rst = 1'b0;
        #10;

        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done_s, 1'b0);
        checkOutput("rst_his", hisMaxScore, 4'h0);
        checkOutput("rst_addr", ram_addr, 4'h0);
        checkOutput("rst_we", ram_we, 1'b0);
        checkOutput("rst_wdata", ram_wdata, 4'h0);
`ifdef NEW_RECORD_EN
        checkOutput("rst_newrec", newRecord_s, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;

        preload(4'd5, 4'd7);
        preload(4'd3, 4'd4);

        // Load idx 5 (holds 7): done exactly 3 cycles after the pulse, no write.
        base = wCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 4'd0);
        waitNeg(2);
        checkOutput("ld_done_early", done_s, 1'b0);
        checkOutput("ld_busy", busy, 1'b1);
        waitNeg(1);
        checkOutput("ld_done", done_s, 1'b1);
        checkOutput("ld_his", hisMaxScore, 4'd7);
        waitNeg(1);
        checkOutput("ld_done_single", done_s, 1'b0);
        checkOutput("ld_idle", busy, 1'b0);
        checkOutput("ld_no_write", wCount - base, 0);

        // Commit 9 over 4 at idx 3: one write, done 5 cycles after the pulse.
        base = wCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd9);
        waitNeg(4);
        checkOutput("cm_done_early", done_s, 1'b0);
        checkOutput("cm_we", ram_we, 1'b1);
        checkOutput("cm_addr", ram_addr, 4'd3);
        checkOutput("cm_wdata", ram_wdata, 4'd9);
        checkOutput("cm_his", hisMaxScore, 4'd9);
        waitNeg(1);
        checkOutput("cm_done", done_s, 1'b1);
        checkOutput("cm_we_low", ram_we, 1'b0);
`ifdef NEW_RECORD_EN
        checkOutput("cm_newrec", newRecord_s, 1'b1);
`endif
        checkOutput("cm_wcount", wCount - base, 1);
        checkOutput("cm_wlog", {wAddrLog[base], wDataLog[base]}, {4'd3, 4'd9});

        // Equal and lower scores never write; hisMaxScore reports the stored 9.
        doLoad("ld5_a", 4'd5, 4'd7);
        base = wCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd9);
        waitNeg(5);
        checkOutput("cm_eq_done", done_s, 1'b1);
        checkOutput("cm_eq_his", hisMaxScore, 4'd9);
`ifdef NEW_RECORD_EN
        checkOutput("cm_eq_newrec", newRecord_s, 1'b0);
`endif
        doLoad("ld5_b", 4'd5, 4'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd2);
        waitNeg(5);
        checkOutput("cm_lo_done", done_s, 1'b1);
        checkOutput("cm_lo_his", hisMaxScore, 4'd9);
`ifdef NEW_RECORD_EN
        checkOutput("cm_lo_newrec", newRecord_s, 1'b0);
`endif
        checkOutput("cm_eqlo_nowrite", wCount - base, 0);

        // All three requests at once: clear, then commit 5 @3, then load 3.
        base     = wCount;
        doneCnt  = 0;
        prevDone = 1'b0;
        dblDone  = 1'b0;
        doneHis[0] = 'x;
        doneHis[1] = 'x;
        doneHis[2] = 'x;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 4'd5);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done_s) begin
                if (doneCnt < 3) begin
                    doneHis[doneCnt] = hisMaxScore;
                end
                doneCnt++;
                if (prevDone) begin
                    dblDone = 1'b1;
                end
            end
            prevDone = done_s;
        end
        checkOutput("all_done_cnt", doneCnt, 3);
        checkOutput("all_done_dbl", dblDone, 1'b0);
        checkOutput("all_his_clr", doneHis[0], 4'd0);
        checkOutput("all_his_cm", doneHis[1], 4'd5);
        checkOutput("all_his_ld", doneHis[2], 4'd5);
        checkOutput("all_wcount", wCount - base, 17);
        for (int i = 0; i < DEPTH; i++) begin
            logic [ADDR_W-1:0] expAddr;
            expAddr = ADDR_W'(i);
            checkOutput($sformatf("clr_w%0d", i),
                        {wAddrLog[base + i], wDataLog[base + i]}, {expAddr, 4'd0});
        end
        checkOutput("all_cm_w", {wAddrLog[base + 16], wDataLog[base + 16]}, {4'd3, 4'd5});
        checkOutput("all_idle", busy, 1'b0);

        // Reset in the middle of a clear sweep at address 6.
        found = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (ram_we && ram_addr == 4'd6 && busy) begin
                found = 1'b1;
            end
        end
        checkOutput("mid_clr_reached", found, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_we", ram_we, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_addr", ram_addr, 4'd0);
        checkOutput("mid_rst_his", hisMaxScore, 4'd0);
        checkOutput("mid_rst_done", done_s, 1'b0);
        base = wCount;
        @(negedge clk);
        rst = 1'b1;
        waitNeg(6);
        checkOutput("post_rst_busy", busy, 1'b0);
        checkOutput("post_rst_nowrite", wCount - base, 0);
        doLoad("post_rst_ld3", 4'd3, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/high_score_keeper.md
Name: high_score_keeper

Overview:
- Sequencer and arbiter for the per-user high-score RAM, indexed by the 4-bit user index chosen on the switches.
- Serves three requesters, each with a one-cycle request pulse:
  - load: fetch a user's stored max score at login;
  - commit: read-compare-write the current score when a game ends;
  - clear-all: zero every entry.
- Sits between the game controller (request pulses, current score) and a single-port synchronous RAM with 1-cycle read latency.
- Drives hisMaxScore to the score display mux.

Parameters:
- SCORE_W, 4, width of a stored score.
- ADDR_W, 4, user-index width.
- DEPTH, 16, RAM entries swept by clear-all (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- loadReq_s  in  1  one-cycle pulse: fetch max score of userIdx.
- commitReq_s  in  1  one-cycle pulse: offer curScore for userIdx.
- clearAllReq_s  in  1  one-cycle pulse: zero all DEPTH entries.
- userIdx  in  ADDR_W  user index; captured with loadReq_s/commitReq_s.
- curScore  in  SCORE_W  score of finished game; captured with commitReq_s.
- hisMaxScore  out  SCORE_W  registered max score of the last-served user.
- busy  out  1  high whenever state != IDLE.
- done_s  out  1  one-cycle pulse when an operation completes.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  SCORE_W  registered RAM write data.
- ram_rdata  in  SCORE_W  RAM read data, valid the cycle after the RAM samples ram_addr.

Behaviour:
- Reset (async, rst==0):
  - state=IDLE; all pending bits, captured operands and clear counter = 0.
  - hisMaxScore=0, busy=0, done_s=0, ram_addr=0, ram_we=0, ram_wdata=0.
  - Reset mid-operation aborts it immediately. A partial clear sweep or an unissued write is simply lost.
- Request capture:
  - Each request type has one pending slot.
  - A pulse sets the slot and captures its operands (load: idx; commit: idx and score), regardless of busy.
  - A repeat pulse while the slot is still pending overwrites its operands (last wins).
  - If a pulse arrives on the same edge its slot is granted, the slot is set again (set wins over grant-clear). The pulse is serviced as a new operation.
- Arbitration (IDLE only): fixed priority clear > commit > load. Granting clears that slot. Ungranted slots stay pending.
- States: IDLE, LD_ADDR, LD_CAP, CM_ADDR, CM_WAIT, CM_CMP, CLR, DONE.
- Load:
  - IDLE -> LD_ADDR: ram_addr<=idx, ram_we<=0.
  - LD_ADDR -> LD_CAP.
  - LD_CAP: hisMaxScore<=ram_rdata, done_s<=1, -> IDLE.
  - From idle, done_s is high 3 cycles after the loadReq_s cycle.
- Commit:
  - IDLE -> CM_ADDR: ram_addr<=idx.
  - CM_ADDR -> CM_WAIT.
  - CM_WAIT -> CM_CMP.
  - CM_CMP, if curScore > ram_rdata (unsigned, strictly greater): ram_we<=1, ram_wdata<=curScore, hisMaxScore<=curScore.
  - CM_CMP, otherwise: hisMaxScore<=ram_rdata, no write.
  - CM_CMP -> DONE. DONE: ram_we<=0, done_s<=1, -> IDLE.
  - Equal score never writes. From idle, done_s is high 5 cycles after the commitReq_s cycle.
- Clear:
  - IDLE -> CLR: ram_addr<=0, ram_we<=1, ram_wdata<=0.
  - Each CLR cycle increments ram_addr. After address DEPTH-1 is written -> DONE.
  - In DONE: hisMaxScore<=0, done_s<=1, ram_we<=0.
  - No wrap: the counter stops at DEPTH-1.
- ram_we is asserted only in CLR and in the single cycle following CM_CMP when a write is issued.
- done_s is never high for two consecutive cycles. One done_s per granted operation.

Optional Feature:
- NEW_RECORD_EN defined:
  - adds output newRecord_s (1 bit, reset 0);
  - pulses with done_s only for a commit that wrote a strictly higher score.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package hs_pkg:
  - state encoding constants (IDLE..DONE);
  - default SCORE_W/ADDR_W/DEPTH;
  - request-type codes (REQ_CLR, REQ_CM, REQ_LD) used by the arbiter.
- One natural sub-module: hs_req_slot, a pending bit plus operand register with set-wins-over-clear. Instantiated three times.

Test Plan:
- Entry 5 = 7; loadReq_s idx 5 -> done_s 3 cycles later, hisMaxScore=7, ram_we never high.
- Entry 3 = 4; commitReq_s idx 3 score 9 -> one ram_we cycle with ram_addr=3, ram_wdata=9; hisMaxScore=9; done_s 5 cycles after request.
- Entry 3 = 9; commit score 9, then score 2 -> no writes; hisMaxScore=9 both times.
- loadReq_s, commitReq_s and clearAllReq_s in the same cycle:
  - service order clear (16 writes of 0 to addr 0..15), then commit, then load;
  - exactly 3 done_s pulses.
- rst low during CLR at addr 6 -> outputs reset immediately, ram_we=0; after release busy=0 and no pending work.
- NEW_RECORD_EN defined: commit 9 over 4 -> newRecord_s=1 with done_s; commit 2 over 9 -> newRecord_s stays 0.
